// File: rtl/logic_op_unit.sv
// Registered bitwise logic unit with valid/ready handshake and multi-beat accumulate mode.
// Optional macro LOGIC_OP_PARITY_EN adds a registered even-parity output y_par = ^y.
module logic_op_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] beats,
`ifdef LOGIC_OP_PARITY_EN
  output logic             y_par,
`endif
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic { IDLE, ACC } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sacc_q, sacc_d;
  logic [WIDTH-1:0] y_d;
  logic [CNT_W-1:0] beats_d;
  logic             sat_d;
  logic             valid_d;
  logic             in_xfer;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] acc_nxt;

  // Combine step: AND/OR/XOR families; PASS/NOT take the newest operand q.
  function automatic logic [WIDTH-1:0] base_f(input logic [2:0] f, input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] q);
    case (f)
      3'b000, 3'b011: base_f = p & q;
      3'b001, 3'b100: base_f = p | q;
      3'b010, 3'b101: base_f = p ^ q;
      default:        base_f = q;
    endcase
  endfunction

  // Inversion applied once, at the output only.
  function automatic logic [WIDTH-1:0] final_f(input logic [2:0] f, input logic [WIDTH-1:0] v);
    case (f)
      3'b011, 3'b100, 3'b101, 3'b111: final_f = ~v;
      default:                        final_f = v;
    endcase
  endfunction

  assign in_ready = !(out_valid && !out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign cnt_hit  = (cnt_q == CNT_MAX);
  assign cnt_inc  = cnt_hit ? cnt_q : cnt_q + CNT_ONE;
  assign acc_nxt  = base_f(op_q, acc_q, a);

  // Next-state and result-register update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sacc_d  = sacc_q;
    y_d     = y;
    beats_d = beats;
    sat_d   = sat;
    valid_d = out_valid && !out_ready;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (!acc_mode || in_last) begin
            y_d     = final_f(op, base_f(op, b, a));
            beats_d = CNT_ONE;
            sat_d   = 1'b0;
            valid_d = 1'b1;
          end else begin
            acc_d   = base_f(op, b, a);
            op_d    = op;
            cnt_d   = CNT_ONE;
            sacc_d  = 1'b0;
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (in_xfer) begin
          acc_d  = acc_nxt;
          cnt_d  = cnt_inc;
          sacc_d = sacc_q || cnt_hit;
          if (in_last) begin
            y_d     = final_f(op_q, acc_nxt);
            beats_d = cnt_inc;
            sat_d   = sacc_q || cnt_hit;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      sacc_q    <= 1'b0;
      y         <= '0;
      beats     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      sacc_q    <= sacc_d;
      y         <= y_d;
      beats     <= beats_d;
      sat       <= sat_d;
      out_valid <= valid_d;
    end
  end

`ifdef LOGIC_OP_PARITY_EN
  // Parity tracks y exactly since both load from y_d
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_par <= 1'b0;
    else     y_par <= ^y_d;
  end
`endif

endmodule

// File: tb/tb_logic_op_unit.sv
// Scoreboard bench for logic_op_unit (WIDTH=8, CNT_W=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_logic_op_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       acc_mode;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] beats;
  logic       sat;
`ifdef LOGIC_OP_PARITY_EN
  logic       y_par;
`endif

  logic_op_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .beats(beats),
`ifdef LOGIC_OP_PARITY_EN
    .y_par(y_par),
`endif
    .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] beats;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a result is consumed at the next posedge whenever valid&ready here
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output y=%h beats=%0d sat=%0b", y, beats, sat);
      end else begin
        e = exp_q.pop_front();
        if (y !== e.y || beats !== e.beats || sat !== e.sat) begin
          errors++;
          $display("FAIL result got y=%h beats=%0d sat=%0b want y=%h beats=%0d sat=%0b",
                   y, beats, sat, e.y, e.beats, e.sat);
        end
`ifdef LOGIC_OP_PARITY_EN
        checks++;
        if (y_par !== ^e.y) begin
          errors++;
          $display("FAIL y_par got %0b want %0b", y_par, ^e.y);
        end
`endif
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic expect_res(input logic [7:0] ey, input logic [3:0] eb, input logic es);
    exp_t e;
    e.y = ey; e.beats = eb; e.sat = es;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One input beat; waits (bounded) for in_ready, transfers on the next posedge
  task automatic beat(input logic [7:0] ta, input logic [7:0] tbv, input logic [2:0] top,
                      input logic tacc, input logic tlast);
    a = ta; b = tbv; op = top; acc_mode = tacc; in_last = tlast; in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n == 59) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout");
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] ss_exp [8];
  int         pidx;

  initial begin
    ss_exp = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'hC3, 8'h3C};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_mode = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_beats", 32'(beats), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Leave a non-zero y behind, then abort a 3-beat packet with reset
    expect_res(8'h3C, 4'd1, 1'b0);
    beat(8'hFF, 8'h3C, 3'b000, 1'b0, 1'b0);
    drain();
    beat(8'h01, 8'h00, 3'b001, 1'b1, 1'b0);
    beat(8'h02, 8'h00, 3'b001, 1'b1, 1'b0);
    beat(8'h04, 8'h00, 3'b001, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("midacc_rst_out_valid", 32'(out_valid), 32'd0);
    check("midacc_rst_y", 32'(y), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_res(8'hFF, 4'd1, 1'b0);
    beat(8'h0F, 8'hF0, 3'b001, 1'b0, 1'b0);
    drain();

    // All eight ops back to back
    pidx = pop_cyc.size();
    for (int i = 0; i < 8; i++) begin
      expect_res(ss_exp[i], 4'd1, 1'b0);
      beat(8'hC3, 8'hA5, 3'(i), 1'b0, 1'b0);
    end
    drain();
    check("throughput_8_in_8_cycles", 32'(pop_cyc[pidx+7] - pop_cyc[pidx]), 32'd7);

    // Accumulate NOR; op/acc_mode changes mid-packet must be ignored
    expect_res(8'hF0, 4'd3, 1'b0);
    beat(8'h01, 8'h02, 3'b100, 1'b1, 1'b0);
    beat(8'h04, 8'hFF, 3'b000, 1'b0, 1'b0);
    beat(8'h08, 8'hFF, 3'b010, 1'b1, 1'b1);
    drain();

    // Back-pressure: result held, input blocked, then released
    out_ready = 1'b0;
    expect_res(8'h30, 4'd1, 1'b0);
    beat(8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0);
    a = 8'h01; b = 8'h02; op = 3'b001; acc_mode = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_y_held", 32'(y), 32'h30);
    expect_res(8'h03, 4'd1, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Saturation: 20 XOR beats of 0x01
    expect_res(8'h00, 4'd15, 1'b1);
    for (int i = 0; i < 20; i++) beat(8'h01, 8'h00, 3'b010, 1'b1, 1'(i == 19));
    drain();

`ifdef LOGIC_OP_PARITY_EN
    expect_res(8'h07, 4'd1, 1'b0);
    beat(8'hFF, 8'h07, 3'b000, 1'b0, 1'b0);
    drain();
    check("parity_and_07", 32'(y_par), 32'd1);
`endif

    check("final_out_valid_idle", 32'(out_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
